// File: rtl/seq_detect_pkg.sv
// Shared FSM encoding and default widths for the serial sequence detector.
package seq_detect_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_PAT_W  = 4;
  localparam int unsigned DEF_CNT_W  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/seq_detect_core.sv
// Bit-serial history, fill tracking and registered pattern compare.
// SEQ_DETECT_NO_OVERLAP_EN: restart fill after every match so matches never share bits.
module seq_detect_core #(
  parameter int unsigned PAT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic             fill_clr,
  input  logic [PAT_W-1:0] pat,
  output logic             hit,
  output logic             match
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  hist;
  logic [PAT_W-1:0]  hist_next;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_next;

  always_comb begin
    hist_next = {hist[PAT_W-2:0], bit_in};
    fill_next = (fill == FILL_MAX) ? FILL_MAX : fill + 1'b1;
    hit       = shift_en && (fill_next == FILL_MAX) && (hist_next == pat);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      hist  <= '0;
      fill  <= '0;
      match <= 1'b0;
    end else begin
      match <= hit;
      if (shift_en) begin
        hist <= hist_next;
`ifdef SEQ_DETECT_NO_OVERLAP_EN
        fill <= hit ? '0 : fill_next;
`else
        fill <= fill_next;
`endif
      end else if (fill_clr) begin
        fill <= '0;
      end
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Word-to-bit scheduler, config registers and saturating match counter with sticky irq.
// Overlap behaviour is selected in seq_detect_core via SEQ_DETECT_NO_OVERLAP_EN.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned PAT_W  = DEF_PAT_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pat,
  input  logic [CNT_W-1:0]  cfg_thresh,
  input  logic              clear,
  output logic              busy,
  output logic              match,
  output logic [CNT_W-1:0]  match_count,
  output logic              irq
);

  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t            state;
  state_t            state_next;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] word;
  logic [PAT_W-1:0]  pat;
  logic [CNT_W-1:0]  thresh;
  logic              accept;
  logic              cfg_load;
  logic              shift_en;
  logic              hit;
  logic [CNT_W-1:0]  count_inc;

  assign in_ready = (state == IDLE) && enable;
  assign busy     = (state == SHIFT);
  assign accept   = in_valid && in_ready;
  assign shift_en = (state == SHIFT);
  // Config is only taken on an idle edge that does not also accept a word.
  assign cfg_load = cfg_we && (state == IDLE) && !accept;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SHIFT;
      SHIFT:   if (bit_idx == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bit_idx <= '0;
      word    <= '0;
      pat     <= '0;
      thresh  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        word    <= in_data;
        bit_idx <= IDX_W'(DATA_W - 1);
      end else if (shift_en) begin
        bit_idx <= bit_idx - 1'b1;
      end
      if (cfg_load) begin
        pat    <= cfg_pat;
        thresh <= cfg_thresh;
      end
    end
  end

  seq_detect_core #(
    .PAT_W(PAT_W)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .shift_en (shift_en),
    .bit_in   (word[bit_idx]),
    .fill_clr (cfg_load),
    .pat      (pat),
    .hit      (hit),
    .match    (match)
  );

  assign count_inc = (match_count == '1) ? match_count : match_count + 1'b1;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      match_count <= '0;
      irq         <= 1'b0;
    end else if (hit) begin
      match_count <= count_inc;
      if ((thresh != '0) && (count_inc == thresh)) irq <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed and randomized checks of seq_detect_ctrl against a queue-based stream model.
module tb_seq_detect_ctrl;

  localparam int DATA_W = 8;
  localparam int PAT_W  = 4;
  localparam int CNT_W  = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset, enable, in_valid, cfg_we, clear;
  logic [DATA_W-1:0] in_data;
  logic [PAT_W-1:0]  cfg_pat;
  logic [CNT_W-1:0]  cfg_thresh;
  logic              in_ready, busy, match, irq;
  logic [CNT_W-1:0]  match_count;

  seq_detect_ctrl #(
    .DATA_W(DATA_W),
    .PAT_W (PAT_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .cfg_we     (cfg_we),
    .cfg_pat    (cfg_pat),
    .cfg_thresh (cfg_thresh),
    .clear      (clear),
    .busy       (busy),
    .match      (match),
    .match_count(match_count),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: stream bits since last clear/cfg/match-restart kept in a queue.
  bit              m_busy;
  int              m_idx;
  logic [DATA_W-1:0] m_word;
  int              m_pat, m_thresh, m_count;
  bit              m_irq, m_match;
  bit              q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit q_matches();
    int v = 0;
    if (q.size() != PAT_W) return 1'b0;
    foreach (q[i]) v = v * 2 + int'(q[i]);
    return v == m_pat;
  endfunction

  task automatic model_edge();
    bit hit = 1'b0;
    bit acc = !m_busy && enable && in_valid;
    if (reset) begin
      m_busy = 0; m_idx = 0; m_word = '0; m_pat = 0; m_thresh = 0;
      m_count = 0; m_irq = 0; m_match = 0; q.delete();
      return;
    end
    if (m_busy) begin
      q.push_back(m_word[m_idx]);
      if (q.size() > PAT_W) void'(q.pop_front());
      hit = q_matches();
`ifdef SEQ_DETECT_NO_OVERLAP_EN
      if (hit) q.delete();
`endif
      if (m_idx == 0) m_busy = 0; else m_idx--;
    end else if (acc) begin
      m_word = in_data; m_idx = DATA_W - 1; m_busy = 1;
    end else if (cfg_we) begin
      m_pat = int'(cfg_pat); m_thresh = int'(cfg_thresh); q.delete();
    end
    if (clear) begin
      q.delete(); m_count = 0; m_irq = 0; m_match = 0;
    end else begin
      m_match = hit;
      if (hit) begin
        if (m_count < CNT_MAX) m_count++;
        if (m_thresh != 0 && m_count == m_thresh) m_irq = 1;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("busy", 32'(busy), 32'(m_busy));
    chk("in_ready", 32'(in_ready), 32'(!m_busy && enable));
    chk("match", 32'(match), 32'(m_match));
    chk("match_count", 32'(match_count), 32'(m_count));
    chk("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic send_word(input logic [DATA_W-1:0] w);
    in_valid = 1'b1; in_data = w;
    tick();
    in_valid = 1'b0;
    repeat (DATA_W) tick();
  endtask

  task automatic do_cfg(input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] t);
    cfg_we = 1'b1; cfg_pat = p; cfg_thresh = t;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; in_valid = 1'b0; in_data = '0;
    cfg_we = 1'b0; cfg_pat = '0; cfg_thresh = '0; clear = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Overlapping pattern inside one word
    do_cfg(4'b1011, 8'd0);
    send_word(8'b1011_0110);
`ifdef SEQ_DETECT_NO_OVERLAP_EN
    chk("b6_count", 32'(match_count), 32'd1);
`else
    chk("b6_count", 32'(match_count), 32'd2);
`endif

    // Pattern straddling a word boundary
    do_clear();
    send_word(8'h05);
    in_valid = 1'b1; in_data = 8'h80;
    tick();
    in_valid = 1'b0;
    tick();
    chk("xword_match", 32'(match), 32'd1);
    repeat (DATA_W - 1) tick();
    chk("xword_count", 32'(match_count), 32'd1);

    // Threshold irq, sticky, then clear
    do_clear();
    do_cfg(4'b1011, 8'd3);
    send_word(8'b1011_1011);
    chk("irq_below", 32'(irq), 32'd0);
    send_word(8'b1011_1011);
    chk("irq_set", 32'(irq), 32'd1);
    send_word(8'h00);
    chk("irq_sticky", 32'(irq), 32'd1);
    do_clear();
    chk("clr_count", 32'(match_count), 32'd0);
    chk("clr_irq", 32'(irq), 32'd0);

    // Saturation
    do_cfg(4'b0000, 8'd0);
    repeat (140) send_word(8'h00);
    chk("sat_count", 32'(match_count), 32'(CNT_MAX));

    // cfg_we on accept edge and mid-SHIFT is ignored
    do_clear();
    do_cfg(4'b1011, 8'd0);
    cfg_we = 1'b1; cfg_pat = 4'b0000; cfg_thresh = 8'd1;
    in_valid = 1'b1; in_data = 8'b1011_0110;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    cfg_we = 1'b0;
    repeat (DATA_W - 2) tick();
    chk("cfg_ign_busy", 32'(busy), 32'd0);
`ifdef SEQ_DETECT_NO_OVERLAP_EN
    chk("cfg_ign_count", 32'(match_count), 32'd1);
`else
    chk("cfg_ign_count", 32'(match_count), 32'd2);
`endif
    chk("cfg_ign_irq", 32'(irq), 32'd0);

    // Reset mid-SHIFT
    in_valid = 1'b1; in_data = 8'hB6;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(match_count), 32'd0);

    // Enable dropped mid-SHIFT
    in_valid = 1'b1; in_data = 8'h5A;
    tick();
    enable = 1'b0;
    repeat (DATA_W + 3) tick();
    chk("en_busy", 32'(busy), 32'd0);
    chk("en_ready", 32'(in_ready), 32'd0);
    enable = 1'b1; in_valid = 1'b0;
    tick();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 299) == 0);
      enable     = ($urandom_range(0, 9) != 0);
      in_valid   = $urandom_range(0, 1);
      in_data    = DATA_W'($urandom);
      cfg_we     = ($urandom_range(0, 19) == 0);
      cfg_pat    = PAT_W'($urandom);
      cfg_thresh = CNT_W'($urandom_range(0, 6));
      clear      = ($urandom_range(0, 59) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
